// File: rtl/robo_controlador_fsm.sv
// rtl/robo_controlador_fsm.sv - robot vacuum movement controller with debounced power toggle and battery hysteresis
// Optional build macro: CONTADOR_COLISOES_EN (8-bit saturating front-collision counter on colisoes)
module robo_controlador_fsm #(
  parameter int BAT_BITS   = 8,
  parameter int BAT_MIN    = 32,
  parameter int BAT_HIST   = 8,
  parameter int DEB_CICLOS = 500000,
  parameter int ROT_CICLOS = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                F,
  input  logic                LE,
  input  logic                LD,
  input  logic                T,
  input  logic [BAT_BITS-1:0] bateria,
  input  logic                botao,
  output logic                ligado,
  output logic [3:0]          mov,
  output logic                erro,
  output logic                bateria_baixa,
  output logic [2:0]          estado,
  output logic [7:0]          colisoes
);

  localparam int DW = $clog2(DEB_CICLOS);
  localparam int RW = (ROT_CICLOS > 1) ? $clog2(ROT_CICLOS) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CICLOS - 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(ROT_CICLOS - 1);
  // Thresholds one bit wider than the level so BAT_MIN+BAT_HIST cannot wrap
  localparam logic [BAT_BITS:0] BAT_SET_W = (BAT_BITS + 1)'(BAT_MIN);
  localparam logic [BAT_BITS:0] BAT_CLR_W = (BAT_BITS + 1)'(BAT_MIN + BAT_HIST);

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    FRENTE    = 3'd1,
    ROT_ESQ   = 3'd2,
    ROT_DIR   = 3'd3,
    RE        = 3'd4,
    ERRO      = 3'd5
  } estado_t;

  logic [4:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [BAT_BITS-1:0] bat_q, bat_d;
  logic                deb_q, deb_d, toggle_q, toggle_d, low_q, low_d;
  logic [DW-1:0]       deb_cnt_q, deb_cnt_d;
  estado_t             state_q, state_d;
  logic [RW-1:0]       man_cnt_q, man_cnt_d;
  logic [3:0]          mov_q, mov_d;
  logic                ligado_q, ligado_d, erro_q, erro_d;
  logic                f_s, le_s, ld_s, t_s, botao_s, all_blk, on;
  logic [BAT_BITS:0]   bat_w;
`ifdef CONTADOR_COLISOES_EN
  logic                col_inc;
  logic [7:0]          col_q, col_d;
`endif

  assign f_s     = sync2_q[0];
  assign le_s    = sync2_q[1];
  assign ld_s    = sync2_q[2];
  assign t_s     = sync2_q[3];
  assign botao_s = sync2_q[4];
  assign all_blk = &sync2_q[3:0];
  assign on      = (state_q != DESLIGADO);
  assign bat_w   = {1'b0, bat_q};

  // Input stage: two-flop synchronisers for sensors/button, battery sample register
  always_comb begin
    sync1_d = {botao, T, LD, LE, F};
    sync2_d = sync1_q;
    bat_d   = bateria;
  end

  // Debounce counter and rising-edge toggle pulse, plus low-battery hysteresis flag
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    toggle_d  = 1'b0;
    if (botao_s != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d    = botao_s;
        toggle_d = botao_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    low_d = low_q;
    if (bat_w < BAT_SET_W) begin
      low_d = 1'b1;
    end else if (bat_w >= BAT_CLR_W) begin
      low_d = 1'b0;
    end
  end

  // Movement FSM next state, manoeuvre counter and next-state output decode
  always_comb begin
    state_d   = state_q;
    man_cnt_d = man_cnt_q;
`ifdef CONTADOR_COLISOES_EN
    col_inc   = 1'b0;
`endif
    if (on && (toggle_q || low_q)) begin
      state_d   = DESLIGADO;
      man_cnt_d = '0;
    end else begin
      case (state_q)
        DESLIGADO: begin
          if (toggle_q && !low_q) state_d = FRENTE;
        end
        FRENTE: begin
          man_cnt_d = '0;
          if (f_s) begin
`ifdef CONTADOR_COLISOES_EN
            col_inc = 1'b1;
`endif
            if (!le_s)      state_d = ROT_ESQ;
            else if (!ld_s) state_d = ROT_DIR;
            else if (!t_s)  state_d = RE;
            else            state_d = ERRO;
          end
        end
        ROT_ESQ, ROT_DIR, RE: begin
          if (all_blk) begin
            state_d   = ERRO;
            man_cnt_d = '0;
          end else if (man_cnt_q == ROT_LAST) begin
            state_d   = FRENTE;
            man_cnt_d = '0;
          end else begin
            man_cnt_d = man_cnt_q + 1'b1;
          end
        end
        ERRO: begin
          if (!all_blk) state_d = FRENTE;
        end
        default: state_d = DESLIGADO;
      endcase
    end
    case (state_d)
      FRENTE:  mov_d = 4'b0001;
      ROT_ESQ: mov_d = 4'b0010;
      ROT_DIR: mov_d = 4'b0100;
      RE:      mov_d = 4'b1000;
      default: mov_d = 4'b0000;
    endcase
    ligado_d = (state_d != DESLIGADO);
    erro_d   = (state_d == ERRO);
  end

  // All state registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      bat_q     <= '0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      toggle_q  <= 1'b0;
      low_q     <= 1'b0;
      state_q   <= DESLIGADO;
      man_cnt_q <= '0;
      mov_q     <= '0;
      ligado_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      bat_q     <= bat_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      toggle_q  <= toggle_d;
      low_q     <= low_d;
      state_q   <= state_d;
      man_cnt_q <= man_cnt_d;
      mov_q     <= mov_d;
      ligado_q  <= ligado_d;
      erro_q    <= erro_d;
    end
  end

`ifdef CONTADOR_COLISOES_EN
  // Saturating collision counter; only reset clears it, power-off does not
  always_comb begin
    col_d = col_q;
    if (col_inc && (col_q != 8'hFF)) col_d = col_q + 8'd1;
  end

  // Collision counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) col_q <= '0;
    else     col_q <= col_d;
  end

  assign colisoes = col_q;
`else
  assign colisoes = '0;
`endif

  assign ligado        = ligado_q;
  assign mov           = mov_q;
  assign erro          = erro_q;
  assign bateria_baixa = low_q;
  assign estado        = state_q;

endmodule

// File: tb/tb_robo_controlador_fsm.sv
// tb/tb_robo_controlador_fsm.sv - directed self-checking bench for robo_controlador_fsm
module tb_robo_controlador_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       F, LE, LD, T, botao;
  logic [7:0] bateria;
  logic       ligado, erro, bateria_baixa;
  logic [3:0] mov;
  logic [2:0] estado;
  logic [7:0] colisoes;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  robo_controlador_fsm #(
    .BAT_BITS(8), .BAT_MIN(32), .BAT_HIST(8), .DEB_CICLOS(4), .ROT_CICLOS(8)
  ) dut (
    .clk(clk), .rst(rst), .F(F), .LE(LE), .LD(LD), .T(T),
    .bateria(bateria), .botao(botao), .ligado(ligado), .mov(mov),
    .erro(erro), .bateria_baixa(bateria_baixa), .estado(estado),
    .colisoes(colisoes)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic press();
    botao = 1'b1;
    tick(6);
    botao = 1'b0;
    tick(12);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ligado"}, 32'(ligado), 0);
    check({tag, "_mov"}, 32'(mov), 0);
    check({tag, "_erro"}, 32'(erro), 0);
    check({tag, "_estado"}, 32'(estado), 0);
    check({tag, "_bat"}, 32'(bateria_baixa), 0);
    check({tag, "_col"}, 32'(colisoes), 0);
  endtask

  initial begin
    rst = 1'b1; F = 0; LE = 0; LD = 0; T = 0; botao = 0; bateria = 8'd100;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(4);

    // Power-on: toggle reaches ligado DEB_CICLOS+3 edges after the press
    botao = 1'b1;
    tick(6);
    check("pre_on_ligado", 32'(ligado), 0);
    botao = 1'b0;
    tick(1);
    check("on_ligado", 32'(ligado), 1);
    check("on_estado", 32'(estado), 1);
    check("on_mov", 32'(mov), 4'b0001);
    tick(10);
    botao = 1'b1;
    tick(2);
    botao = 1'b0;
    tick(10);
    check("glitch_ligado", 32'(ligado), 1);
    check("glitch_estado", 32'(estado), 1);

    // Left rotation lasts exactly 8 cycles
    F = 1; LE = 0;
    tick(3);
    check("rotesq_start", 32'(mov), 4'b0010);
    check("rotesq_estado", 32'(estado), 2);
    F = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("rotesq_hold", 32'(mov), 4'b0010);
    end
    tick(1);
    check("rotesq_end", 32'(mov), 4'b0001);

    // Right rotation
    F = 1; LE = 1; LD = 0;
    tick(3);
    check("rotdir_start", 32'(mov), 4'b0100);
    check("rotdir_estado", 32'(estado), 3);
    F = 0;
    tick(7);
    check("rotdir_hold", 32'(mov), 4'b0100);
    tick(1);
    check("rotdir_end", 32'(mov), 4'b0001);

    // Reverse
    F = 1; LE = 1; LD = 1; T = 0;
    tick(3);
    check("re_start", 32'(mov), 4'b1000);
    check("re_estado", 32'(estado), 4);
    F = 0;
    tick(8);
    check("re_end", 32'(mov), 4'b0001);

    // Error, then release LD -> FRENTE then ROT_DIR
    F = 1; LE = 1; LD = 1; T = 1;
    tick(3);
    check("erro_flag", 32'(erro), 1);
    check("erro_estado", 32'(estado), 5);
    check("erro_mov", 32'(mov), 0);
    LD = 0;
    tick(3);
    check("erro_exit_estado", 32'(estado), 1);
    check("erro_exit_erro", 32'(erro), 0);
    tick(1);
    check("erro_reeval_estado", 32'(estado), 3);
    F = 0; LE = 0; T = 0;
    tick(8);
    check("erro_rot_end", 32'(estado), 1);

    // Battery hysteresis
    bateria = 8'd31;
    tick(2);
    check("bat_low_flag", 32'(bateria_baixa), 1);
    check("bat_low_still_on", 32'(ligado), 1);
    tick(1);
    check("bat_low_off", 32'(ligado), 0);
    check("bat_low_estado", 32'(estado), 0);
    bateria = 8'd39;
    tick(3);
    check("bat39_flag", 32'(bateria_baixa), 1);
    press();
    check("bat39_toggle_off", 32'(ligado), 0);
    bateria = 8'd40;
    tick(3);
    check("bat40_flag", 32'(bateria_baixa), 0);
    press();
    check("bat40_on", 32'(ligado), 1);
    check("bat40_estado", 32'(estado), 1);

    // Toggle mid ROT_DIR
    F = 1; LE = 1; LD = 0;
    tick(3);
    check("mid_rot_start", 32'(mov), 4'b0100);
    F = 0; LE = 0;
    botao = 1'b1;
    tick(6);
    check("mid_rot_hold", 32'(mov), 4'b0100);
    botao = 1'b0;
    tick(1);
    check("mid_rot_off", 32'(ligado), 0);
    check("mid_rot_mov", 32'(mov), 0);
    check("mid_rot_estado", 32'(estado), 0);
    tick(12);

    // Next rotation runs the full 8 cycles
    press();
    F = 1; LE = 1; LD = 0;
    tick(3);
    check("full_rot_start", 32'(mov), 4'b0100);
    F = 0; LE = 0;
    tick(7);
    check("full_rot_hold", 32'(mov), 4'b0100);
    tick(1);
    check("full_rot_end", 32'(mov), 4'b0001);

    // Toggle on the same edge as manoeuvre end -> DESLIGADO
    F = 1; LE = 1; LD = 0;
    tick(3);
    check("simul_start", 32'(mov), 4'b0100);
    F = 0; LE = 0;
    tick(1);
    botao = 1'b1;
    tick(6);
    check("simul_hold", 32'(mov), 4'b0100);
    botao = 1'b0;
    tick(1);
    check("simul_estado", 32'(estado), 0);
    check("simul_ligado", 32'(ligado), 0);
    tick(12);

    // Reset asserted in the middle of RE
    press();
    F = 1; LE = 1; LD = 1; T = 0;
    tick(3);
    check("rst_re_mov", 32'(mov), 4'b1000);
`ifdef CONTADOR_COLISOES_EN
    check("col_count9", 32'(colisoes), 9);
`else
    check("col_tied0", 32'(colisoes), 0);
`endif
    rst = 1'b1;
    #1;
    check_all_zero("rst_re");
    F = 0; LE = 0; LD = 0; T = 0;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("post_rst_estado", 32'(estado), 0);

`ifdef CONTADOR_COLISOES_EN
    press();
    F = 1; LE = 1; LD = 1;
    repeat (1500) begin
      T = ~T;
      tick(1);
    end
    F = 0; LE = 0; LD = 0; T = 0;
    tick(12);
    check("col_sat", 32'(colisoes), 255);
    check("col_sat_estado", 32'(estado), 1);
    press();
    check("col_off_ligado", 32'(ligado), 0);
    check("col_off_keep", 32'(colisoes), 255);
    press();
    check("col_on_keep", 32'(colisoes), 255);
    rst = 1'b1;
    #1;
    check("col_rst", 32'(colisoes), 0);
    tick(1);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
